// File: rtl/rcsub_serial.sv
// rcsub_serial: bit-serial ripple-borrow subtractor, d = x - y - b_in, LSB first, one bit per clock.
// Build option RCSUB_SAT_EN: when defined, d is clamped to zero whenever the final borrow is set.
module rcsub_serial #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] d,
    output logic         b_out
);
    localparam int cw = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [n-1:0]   xs, ys, rs, rs_nx;
    logic [cw-1:0]  cnt;
    logic           br, bit_d, br_nx, last;

    assign bit_d = xs[0] ^ ys[0] ^ br;
    assign br_nx = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & br);
    assign last  = cnt == cw'(n - 1);

    // New difference bits enter at the MSB so the result is aligned after n shifts.
    generate
        if (n == 1) begin : g_one
            assign rs_nx = bit_d;
        end else begin : g_wide
            assign rs_nx = {bit_d, rs[n-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // Next state: start only matters in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end

    // Operand capture, per-bit subtraction, and result commit on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            xs    <= '0;
            ys    <= '0;
            rs    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            d     <= '0;
            b_out <= 1'b0;
        end else if (state == IDLE && start) begin
            xs  <= x;
            ys  <= y;
            br  <= b_in;
            cnt <= '0;
        end else if (state == RUN) begin
            xs  <= xs >> 1;
            ys  <= ys >> 1;
            rs  <= rs_nx;
            br  <= br_nx;
            cnt <= cnt + cw'(1);
            if (last) begin
`ifdef RCSUB_SAT_EN
                d <= br_nx ? '0 : rs_nx;
`else
                d <= rs_nx;
`endif
                b_out <= br_nx;
            end
        end
    end
endmodule

// File: tb/tb_rcsub_serial.sv
// tb_rcsub_serial: randomized and directed checks of rcsub_serial against an arithmetic reference.
module tb_rcsub_serial;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, start, b_in;
    logic [N-1:0] x, y, d;
    logic         busy, done, b_out;
    int           total = 0;
    int           bad = 0;

    rcsub_serial #(.n(N)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .b_in(b_in),
        .busy(busy), .done(done), .d(d), .b_out(b_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction, borrow is the sign of the true difference.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] bb, input logic c);
        int           diff;
        logic [N-1:0] r;
        logic         bo;
        diff = int'(a) - int'(bb) - int'(c);
        bo   = diff < 0;
        r    = diff[N-1:0];
`ifdef RCSUB_SAT_EN
        if (bo) r = '0;
`endif
        return {bo, r};
    endfunction

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] bb, input logic c);
        @(negedge clk);
        x = a; y = bb; b_in = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles from the first cycle after acceptance until done; -1 if it never comes.
    task automatic wait_done(output int c, output logic all_busy);
        c = 1;
        all_busy = busy;
        while (!done && c < 20) begin
            @(posedge clk);
            #1;
            c++;
            all_busy &= busy;
        end
        if (!done) c = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; x = '1; y = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (d !== '0) begin bad++; $display("FAIL reset_d got=%h exp=0", d); end
        total++; if (b_out !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b exp=0", b_out); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0] xa [4] = '{4'd9, 4'd3, 4'd0, 4'd15};
        logic [N-1:0] ya [4] = '{4'd3, 4'd9, 4'd0, 4'd15};
        logic         ba [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [N:0]   e;
        logic [N-1:0] prev;
        logic         ab;
        int           c;
        for (int i = 0; i < 4; i++) begin
            prev = d;
            e = model(xa[i], ya[i], ba[i]);
            launch(xa[i], ya[i], ba[i]);
            total++; if (d !== prev) begin bad++; $display("FAIL dir_hold[%0d] got=%h exp=%h", i, d, prev); end
            wait_done(c, ab);
            total++; if (c !== N + 1) begin bad++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, c, N + 1); end
            total++; if (ab !== 1'b1) begin bad++; $display("FAIL dir_busy[%0d] got=%b exp=1", i, ab); end
            total++; if (d !== e[N-1:0]) begin bad++; $display("FAIL dir_d[%0d] got=%h exp=%h", i, d, e[N-1:0]); end
            total++; if (b_out !== e[N]) begin bad++; $display("FAIL dir_bout[%0d] got=%b exp=%b", i, b_out, e[N]); end
            @(posedge clk);
            #1;
            total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL dir_idle[%0d] got=%b exp=00", i, {busy, done}); end
        end
    endtask

    task automatic test_ignore_start();
        logic [N:0]   e;
        logic [N-1:0] got_d;
        logic         got_b;
        int           dn;
        e = model(4'd5, 4'd2, 1'b0);
        got_d = 'x;
        got_b = 1'bx;
        dn = 0;
        launch(4'd5, 4'd2, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            start = k < 2; x = 4'd1; y = 4'd1; b_in = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin dn++; got_d = d; got_b = b_out; end
        end
        start = 1'b0;
        total++; if (dn !== 1) begin bad++; $display("FAIL ign_pulses got=%0d exp=1", dn); end
        total++; if (got_d !== e[N-1:0]) begin bad++; $display("FAIL ign_d got=%h exp=%h", got_d, e[N-1:0]); end
        total++; if (got_b !== e[N]) begin bad++; $display("FAIL ign_bout got=%b exp=%b", got_b, e[N]); end
    endtask

    task automatic test_mid_reset();
        int dn;
        launch(4'd9, 4'd3, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mrst_done got=%b exp=0", done); end
        total++; if (d !== '0) begin bad++; $display("FAIL mrst_d got=%h exp=0", d); end
        total++; if (b_out !== 1'b0) begin bad++; $display("FAIL mrst_bout got=%b exp=0", b_out); end
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL mrst_quiet got=%0d exp=0", dn); end
    endtask

    task automatic test_random();
        logic [N-1:0] a, bb;
        logic         c, ab;
        logic [N:0]   e;
        int           lat;
        for (int i = 0; i < 20; i++) begin
            a = N'($urandom);
            bb = N'($urandom);
            c = 1'($urandom);
            e = model(a, bb, c);
            launch(a, bb, c);
            wait_done(lat, ab);
            total++; if (lat !== N + 1) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, lat, N + 1); end
            total++; if ({b_out, d} !== e) begin bad++; $display("FAIL rnd_result[%0d] x=%h y=%h b=%b got=%h exp=%h", i, a, bb, c, {b_out, d}, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] xq [48];
        logic [N-1:0] yq [48];
        logic         bq [48];
        logic [N:0]   e;
        int           prev, nd, acc;
        prev = -1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            x = N'($urandom); y = N'($urandom); b_in = 1'($urandom); start = 1'b1;
            xq[i] = x; yq[i] = y; bq[i] = b_in;
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                acc = i - N;
                if (acc < 0) begin
                    total++; bad++; $display("FAIL b2b_early got=%0d exp>=%0d", i, N);
                end else begin
                    e = model(xq[acc], yq[acc], bq[acc]);
                    total++; if ({b_out, d} !== e) begin bad++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, {b_out, d}, e); end
                end
                if (prev < 0) begin
                    total++; if (i !== N) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", i, N); end
                end else begin
                    total++; if (i - prev !== N + 2) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", i - prev, N + 2); end
                end
                prev = i;
            end
        end
        start = 1'b0;
        total++; if (nd !== 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", nd); end
        repeat (N + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
